routine_sequencer: RTL and testbench

//  Top-level scheduler for the light routines. Shares the LED bar and the four 7-segment displays among NUM_ROUTINES routine blocks.

---
 rtl/light_pkg.sv | 14 +
 rtl/rise_detect.sv | 12 +
 rtl/routine_sequencer.sv | 101 ++++++++++
 tb/tb_routine_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// light_pkg: shared routine-bus field layout and sequencer state encoding for the light board
package light_pkg;
    localparam int BUS_W    = 47;
    localparam int DONE_BIT = 46;
    localparam int LED_HI   = 45;
    localparam int LED_LO   = 28;
    localparam int SSD_HI   = 27;
    localparam int SSD_LO   = 0;
    localparam logic [27:0] SSD_BLANK = 28'hFFFFFFF;
    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle pulse on a rising input; prev resets high so a level held through reset never pulses
module rise_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic In,
    output logic Pulse
);
    logic prev_q, prev_d;
    always_comb prev_d = In;
    always_ff @(posedge Clock) prev_q <= Reset ? 1'b1 : prev_d;
    assign Pulse = In & ~prev_q;
endmodule

// File: rtl/routine_sequencer.sv
// routine_sequencer: time-shares the LED bar and 7-segment displays among routine blocks, one at a time
module routine_sequencer
    import light_pkg::*;
#(
    parameter int NUM_ROUTINES = 4,
    parameter int SEL_W        = 2,
    parameter int TIMEOUT      = 1024,
    parameter int CNT_W        = 10,
    parameter int MIN_DWELL    = 4
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          NextBtn,
    input  logic                          Hold,
    input  logic                          ManualMode,
    input  logic [SEL_W-1:0]              ManualSel,
    input  logic [BUS_W*NUM_ROUTINES-1:0] RoutineBus,
    output logic [NUM_ROUTINES-1:0]       RoutineReset,
    output logic [17:0]                   LedOut,
    output logic [27:0]                   SsdOut,
    output logic [SEL_W-1:0]              ActiveIdx,
    output logic                          Loading,
    output logic [7:0]                    PassCount
);
    localparam logic [SEL_W-1:0] LAST      = SEL_W'(NUM_ROUTINES - 1);
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DWELL_MIN = CNT_W'(MIN_DWELL);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [7:0]       pass_q, pass_d;
    logic [17:0]      led_q, led_d;
    logic [27:0]      ssd_q, ssd_d;
    logic             next_pulse, sel_ok, auto_adv;
    logic [BUS_W-1:0] bus_sel;

    rise_detect u_next (
        .Clock (Clock),
        .Reset (Reset),
        .In    (NextBtn),
        .Pulse (next_pulse)
    );

    assign bus_sel  = RoutineBus[BUS_W*int'(idx_q) +: BUS_W];
    assign sel_ok   = int'(ManualSel) < NUM_ROUTINES;
    // done is only trusted after MIN_DWELL: a routine may still show done from before its reset
    assign auto_adv = (dwell_q >= DWELL_MIN && (bus_sel[DONE_BIT] || next_pulse)) || dwell_q == DWELL_MAX;

    always_comb begin
        state_d = ST_RUN;
        idx_d   = idx_q;
        dwell_d = '0;
        pass_d  = pass_q;
        led_d   = '0;
        ssd_d   = SSD_BLANK;
        if (state_q == ST_RUN) begin
            dwell_d = dwell_q == DWELL_MAX ? dwell_q : dwell_q + 1'b1;
            led_d   = bus_sel[LED_HI:LED_LO];
            ssd_d   = bus_sel[SSD_HI:SSD_LO];
            if (ManualMode) begin
                if (sel_ok && ManualSel != idx_q) begin
                    idx_d   = ManualSel;
                    state_d = ST_LOAD;
                end
            end else if (!Hold && auto_adv) begin
                idx_d   = idx_q == LAST ? '0 : idx_q + 1'b1;
                pass_d  = idx_q == LAST ? pass_q + 1'b1 : pass_q;
                state_d = ST_LOAD;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            dwell_q <= '0;
            pass_q  <= '0;
            led_q   <= '0;
            ssd_q   <= SSD_BLANK;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            pass_q  <= pass_d;
            led_q   <= led_d;
            ssd_q   <= ssd_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ROUTINES; i++) RoutineReset[i] = state_q == ST_LOAD || idx_q != SEL_W'(i);
    end

    assign Loading   = state_q == ST_LOAD;
    assign ActiveIdx = idx_q;
    assign PassCount = pass_q;
    assign LedOut    = led_q;
    assign SsdOut    = ssd_q;
endmodule

// File: tb/tb_routine_sequencer.sv
// tb_routine_sequencer: scoreboard bench; each expected advance is queued when stimulus is driven and checked at LOAD
module tb_routine_sequencer;
    logic          Clock = 1'b0;
    logic          Reset, NextBtn, Hold, ManualMode, ManualMode3;
    logic [1:0]    ManualSel, ManualSel3, ActiveIdx, ActiveIdx3;
    logic [187:0]  RoutineBus;
    logic [140:0]  RoutineBus3;
    logic [3:0]    RoutineReset, done4;
    logic [2:0]    RoutineReset3, done3;
    logic [17:0]   LedOut, LedOut3;
    logic [27:0]   SsdOut, SsdOut3;
    logic          Loading, Loading3;
    logic [7:0]    PassCount, PassCount3;

    typedef struct {
        logic [1:0] idx;
        int         run;
        logic [7:0] pass;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_err = 0, rc = 0, loads3 = 0;
    logic was_load = 1'b1;

    always #5 Clock = ~Clock;

    always_comb begin
        for (int i = 0; i < 4; i++) RoutineBus[47*i +: 47] = {done4[i], 18'h2A5A0 + 18'(i), 28'h1234560 + 28'(i)};
        for (int i = 0; i < 3; i++) RoutineBus3[47*i +: 47] = {done3[i], 18'h2A5A0 + 18'(i), 28'h1234560 + 28'(i)};
    end

    routine_sequencer #(.NUM_ROUTINES(4), .SEL_W(2), .TIMEOUT(64), .CNT_W(6), .MIN_DWELL(4)) dut (
        .Clock(Clock), .Reset(Reset), .NextBtn(NextBtn), .Hold(Hold), .ManualMode(ManualMode),
        .ManualSel(ManualSel), .RoutineBus(RoutineBus), .RoutineReset(RoutineReset), .LedOut(LedOut),
        .SsdOut(SsdOut), .ActiveIdx(ActiveIdx), .Loading(Loading), .PassCount(PassCount)
    );

    routine_sequencer #(.NUM_ROUTINES(3), .SEL_W(2), .TIMEOUT(64), .CNT_W(6), .MIN_DWELL(4)) dut3 (
        .Clock(Clock), .Reset(Reset), .NextBtn(NextBtn), .Hold(Hold), .ManualMode(ManualMode3),
        .ManualSel(ManualSel3), .RoutineBus(RoutineBus3), .RoutineReset(RoutineReset3), .LedOut(LedOut3),
        .SsdOut(SsdOut3), .ActiveIdx(ActiveIdx3), .Loading(Loading3), .PassCount(PassCount3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // rc counts RUN cycles since the last LOAD; at a new LOAD it holds the length of the finished run
    task automatic tick();
        exp_t e;
        @(negedge Clock);
        if (Loading && !was_load && !Reset) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("adv_idx", ActiveIdx, e.idx);
                check("adv_run", rc, e.run);
                check("adv_pass", PassCount, e.pass);
            end
        end
        was_load = Loading;
        rc = Loading ? 0 : rc + 1;
    endtask

    task automatic run_until(input int m);
        int n = 0;
        while (rc < m && n < 200) begin
            tick();
            n++;
        end
        check("run_until", rc, m);
    endtask

    task automatic wait_load();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!Loading && n < 200);
        check("load_timeout", Loading, 1);
    endtask

    initial begin
        int n;
        Reset = 1; NextBtn = 1; Hold = 0; ManualMode = 0; ManualSel = 0;
        ManualMode3 = 0; ManualSel3 = 0; done4 = '0; done3 = '0;
        repeat (3) tick();
        check("rst_loading", Loading, 1);
        check("rst_rreset", RoutineReset, 4'hF);
        check("rst_idx", ActiveIdx, 0);
        check("rst_led", LedOut, 0);
        check("rst_ssd", SsdOut, 28'hFFFFFFF);
        check("rst_pass", PassCount, 0);
        Reset = 0;
        // routine 0 done at dwell 30; NextBtn stays high from reset and must not count as a press
        run_until(31);
        done4[0] = 1;
        sb.push_back('{2'd1, 31, 8'd0});
        tick();
        check("t1_load_rreset", RoutineReset, 4'hF);
        done4[0] = 0;
        tick();
        check("t1_run_rreset", RoutineReset, 4'b1101);
        tick();
        check("t1_led", LedOut, 18'h2A5A1);
        check("t1_ssd", SsdOut, 28'h1234561);
        // Next press advances routine 1; routine 2 enters RUN with done already high
        done4[2] = 1;
        NextBtn = 0;
        run_until(10);
        NextBtn = 1;
        sb.push_back('{2'd2, 10, 8'd0});
        tick();
        sb.push_back('{2'd3, 5, 8'd0});
        wait_load();
        done4[2] = 0;
        // Hold blocks done and a Next press; release advances on done and wraps the pass
        Hold = 1;
        done4[3] = 1;
        NextBtn = 0;
        run_until(8);
        NextBtn = 1;
        run_until(20);
        check("t4_hold_idx", ActiveIdx, 3);
        Hold = 0;
        sb.push_back('{2'd0, 20, 8'd1});
        tick();
        done4[3] = 0;
        // a press swallowed by Hold is not replayed: timeout decides, then three more timeouts wrap
        Hold = 1;
        NextBtn = 0;
        run_until(4);
        NextBtn = 1;
        run_until(12);
        Hold = 0;
        sb.push_back('{2'd1, 64, 8'd1});
        wait_load();
        sb.push_back('{2'd2, 64, 8'd1});
        wait_load();
        sb.push_back('{2'd3, 64, 8'd1});
        wait_load();
        sb.push_back('{2'd0, 64, 8'd2});
        wait_load();
        check("t3_pass", PassCount, 2);
        // step to routine 2 with presses, then reset mid-RUN with NextBtn held
        NextBtn = 0;
        run_until(6);
        NextBtn = 1;
        sb.push_back('{2'd1, 6, 8'd2});
        tick();
        NextBtn = 0;
        run_until(6);
        NextBtn = 1;
        sb.push_back('{2'd2, 6, 8'd2});
        tick();
        run_until(10);
        check("t6_led_pre", LedOut, 18'h2A5A2);
        Reset = 1;
        tick();
        tick();
        check("t6_loading", Loading, 1);
        check("t6_idx", ActiveIdx, 0);
        check("t6_led", LedOut, 0);
        check("t6_ssd", SsdOut, 28'hFFFFFFF);
        check("t6_pass", PassCount, 0);
        check("t6_rreset", RoutineReset, 4'hF);
        Reset = 0;
        sb.push_back('{2'd1, 64, 8'd0});
        // three-routine instance in manual mode: valid select loads, out-of-range select and done are ignored
        ManualMode3 = 1;
        ManualSel3 = 2;
        n = 0;
        do begin
            tick();
            n++;
        end while (!Loading3 && n < 20);
        check("t5_load3", Loading3, 1);
        check("t5_idx3", ActiveIdx3, 2);
        ManualSel3 = 3;
        done3[2] = 1;
        repeat (70) begin
            tick();
            if (Loading3) loads3++;
        end
        check("t5_no_loads", loads3, 0);
        check("t5_idx_kept", ActiveIdx3, 2);
        // leaving manual keeps the saturated dwell, so timeout fires on the next edge and wraps 2 -> 0
        ManualMode3 = 0;
        done3[2] = 0;
        tick();
        check("t5_auto_load", Loading3, 1);
        check("t5_auto_idx", ActiveIdx3, 0);
        check("t5_auto_pass", PassCount3, 1);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
